// File: rtl/uart_dump_ctrl_pkg.sv
// Shared monitor definitions: dump sequencer states, ASCII control characters
// and the nibble-to-hex-ASCII helper also used by the PC print path.
package uart_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HEX,
    ST_SEP,
    ST_CR,
    ST_LF
  } dump_state_e;

  localparam logic [7:0] CHR_CR = 8'h0d;
  localparam logic [7:0] CHR_LF = 8'h0a;
  localparam logic [7:0] CHR_SP = 8'h20;

  // 0-9 -> '0'..'9', a-f -> lowercase 'a'..'f' (0x57 + 10 = 0x61)
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_dump_ctrl_hex_byte_serializer.sv
// Streams a 32-bit word as 8 lowercase hex ASCII bytes, MSB nibble first,
// over valid/ready; done_o pulses on the accepting edge of the eighth byte.
module hex_byte_serializer
  import uart_dump_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        done_o
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        accept;

  always_comb begin
    accept  = valid_q & ready_i;
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      // shift so the presented nibble is always word_q[31:28]
      word_d = {word_q[27:0], 4'h0};
      cnt_d  = cnt_q + 3'd1;
      if (flush_i || cnt_q == 3'd7) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = nib2ascii(word_q[31:28]);
  assign done_o  = accept & (cnt_q == 3'd7);

endmodule

// File: rtl/uart_dump_ctrl.sv
// Memory dump sequencer for the monitor 'r'/'p' commands: reads start..end,
// prints each word as hex with space / CR LF framing, and supports abort.
module uart_dump_ctrl
  import uart_dump_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_data,
  input  logic        read_start_set,
  input  logic        read_end_set,
  input  logic        read_stop,
  output logic        dump_running,
  output logic [31:0] mem_raddr,
  output logic        mem_rreq,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [3:0] COL_LAST = 4'(WORDS_PER_LINE - 1);

  dump_state_e state_q, state_d;
  logic [31:0] start_q, start_d;
  logic [31:0] end_q, end_d;
  logic [31:0] cur_q, cur_d;
  logic [3:0]  col_q, col_d;
  logic        abort_q, abort_d;
  logic        abort_now, last_word;
  logic        ser_load, ser_valid, ser_done;
  logic [7:0]  ser_data;

  assign abort_now = abort_q | read_stop;
  // covers both cur == end and an end address below the start address
  assign last_word = (cur_q >= end_q);

  hex_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .word_i  (mem_rdata),
    .load_i  (ser_load),
    .flush_i (abort_now),
    .ready_i (tx_ready),
    .valid_o (ser_valid),
    .data_o  (ser_data),
    .done_o  (ser_done)
  );

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    cur_d        = cur_q;
    col_d        = col_q;
    abort_d      = abort_now;
    dump_running = (state_q != ST_IDLE);
    mem_rreq     = 1'b0;
    mem_raddr    = '0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    ser_load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (read_start_set) begin
          start_d = uart_data & 32'hFFFF_FFFC;
        end else if (read_end_set) begin
          end_d   = uart_data & 32'hFFFF_FFFC;
          cur_d   = start_q;
          col_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_rreq  = 1'b1;
        mem_raddr = cur_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (abort_now) begin
            state_d = ST_IDLE;
          end else begin
            ser_load = 1'b1;
            state_d  = ST_HEX;
          end
        end
      end
      ST_HEX: begin
        tx_valid = ser_valid;
        tx_data  = ser_data;
        if (ser_valid && tx_ready && abort_now) begin
          state_d = ST_IDLE;
        end else if (ser_done) begin
          if (last_word || col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_CR;
          end else begin
            col_d   = col_q + 4'd1;
            state_d = ST_SEP;
          end
        end
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = CHR_CR;
        if (tx_ready) begin
          state_d = abort_now ? ST_IDLE : ST_LF;
        end
      end
      ST_SEP, ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = (state_q == ST_SEP) ? CHR_SP : CHR_LF;
        if (tx_ready) begin
          if (abort_now || last_word) begin
            state_d = ST_IDLE;
          end else begin
            cur_d   = cur_q + 32'd4;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      end_q   <= '0;
      cur_q   <= '0;
      col_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      cur_q   <= cur_d;
      col_q   <= col_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Scoreboard bench for uart_dump_ctrl: expected read addresses and UART bytes
// are queued per dump; independent processes model memory and check the UART.
module tb_uart_dump_ctrl;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] uart_data = '0;
  logic        read_start_set = 1'b0;
  logic        read_end_set = 1'b0;
  logic        read_stop = 1'b0;
  logic        dump_running;
  logic [31:0] mem_raddr;
  logic        mem_rreq;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  uart_dump_ctrl #(.WORDS_PER_LINE(WPL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_data      (uart_data),
    .read_start_set (read_start_set),
    .read_end_set   (read_end_set),
    .read_stop      (read_stop),
    .dump_running   (dump_running),
    .mem_raddr      (mem_raddr),
    .mem_rreq       (mem_rreq),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mem_ovr[logic [31:0]];
  logic [31:0] seed = 32'h1357_9bdf;
  string       hexdig = "0123456789abcdef";
  int          ready_mode = 1;   // 0 random, 1 high, 2 low
  int          lat_fixed = 1;    // 0 -> random 1..5
  int          acc_cnt = 0;
  int          rreq_cnt = 0;
  logic        seen_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // Reference: word count from the address range, line break every WPL words
  task automatic plan(input logic [31:0] s_raw, input logic [31:0] e_raw);
    logic [31:0] s, e, a, w;
    int n;
    s = s_raw & 32'hFFFF_FFFC;
    e = e_raw & 32'hFFFF_FFFC;
    n = (e >= s) ? int'((e - s) >> 2) + 1 : 1;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      w = memval(a);
      exp_addr.push_back(a);
      for (int k = 0; k < 8; k++) exp_q.push_back(hexdig.getc(int'(w[31 - 4 * k -: 4])));
      if (i == n - 1 || (i % WPL) == WPL - 1) begin
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
      end else begin
        exp_q.push_back(8'h20);
      end
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    uart_data = s; read_start_set = 1'b1;
    @(negedge clk);
    read_start_set = 1'b0; uart_data = e; read_end_set = 1'b1;
    @(negedge clk);
    read_end_set = 1'b0;
    chk("running_rise", {31'b0, dump_running}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || dump_running) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_in_time"}, {31'b0, c < budget}, 32'd1);
    chk({name, "_bytes_left"}, exp_q.size(), 32'd0);
    chk({name, "_reads_left"}, exp_addr.size(), 32'd0);
  endtask

  // UART ready generator
  always @(negedge clk) begin
    case (ready_mode)
      0:       tx_ready = ($urandom_range(0, 2) != 0);
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'b0;
    endcase
  end

  // Memory model: one outstanding read, variable latency
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          lat_left = 0;
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend) begin
      if (lat_left <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memval(pend_addr);
        pend       = 1'b0;
      end else begin
        lat_left--;
      end
    end
    if (mem_rreq && rst_n) begin
      rreq_cnt++;
      if (exp_addr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got read at 0x%08h, required no read", mem_raddr);
      end else begin
        chk("rd_addr", mem_raddr, exp_addr.pop_front());
      end
      pend      = 1'b1;
      pend_addr = mem_raddr;
      lat_left  = (lat_fixed == 0) ? int'($urandom_range(1, 5)) : lat_fixed;
    end
  end

  // UART monitor: pops the scoreboard on each handshake, checks stall stability
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (tx_valid) seen_valid = 1'b1;
      if (stall_prev) begin
        chk("stall_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, stall_data});
      end
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got byte 0x%02h, required none", tx_data);
        end else begin
          chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic abort_mem(input logic [31:0] s, input int dly, input string name);
    int r0;
    lat_fixed = 6; ready_mode = 1;
    r0 = rreq_cnt;
    exp_addr.push_back(s);
    launch(s, s + 32'd12);
    repeat (dly) @(negedge clk);
    read_stop = 1'b1;
    @(negedge clk);
    read_stop = 1'b0;
    wait_done(name, 40);
    repeat (10) @(negedge clk);
    chk({name, "_idle"}, {31'b0, dump_running}, 32'd0);
    chk({name, "_reads"}, rreq_cnt - r0, 32'd1);
  endtask

  initial begin
    int r0, base, c;
    logic [31:0] s, e, w;

    repeat (3) @(negedge clk);
    chk("rst_running", {31'b0, dump_running}, 32'd0);
    chk("rst_rreq", {31'b0, mem_rreq}, 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_txvalid", {31'b0, tx_valid}, 32'd0);
    chk("rst_txdata", {24'b0, tx_data}, 32'd0);
    rst_n = 1'b1;

    // Known words, one line, latency 1, no stalls
    mem_ovr[32'h10] = 32'h1234_5678;
    mem_ovr[32'h14] = 32'h9abc_def0;
    mem_ovr[32'h18] = 32'h0000_0001;
    mem_ovr[32'h1c] = 32'hffff_ffff;
    lat_fixed = 1; ready_mode = 1;
    plan(32'h10, 32'h1c);
    launch(32'h10, 32'h1c);
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin @(negedge clk); c++; end
    chk("line_in_time", {31'b0, c < 200}, 32'd1);
    chk("running_fall", {31'b0, dump_running}, 32'd0);
    mem_ovr.delete();

    // Two lines with random stalls and latency; start/end pulses mid-dump ignored
    lat_fixed = 0; ready_mode = 0; seed = $urandom;
    plan(32'h0, 32'h14);
    launch(32'h0, 32'h14);
    repeat (5) @(negedge clk);
    uart_data = 32'hdead_0000; read_start_set = 1'b1; read_end_set = 1'b1;
    @(negedge clk);
    read_start_set = 1'b0; read_end_set = 1'b0;
    wait_done("two_lines", 2000);

    // End below start: one word, one read
    ready_mode = 1; lat_fixed = 2;
    r0 = rreq_cnt;
    plan(32'h20, 32'h10);
    launch(32'h20, 32'h10);
    wait_done("end_lt_start", 200);
    chk("end_lt_start_reads", rreq_cnt - r0, 32'd1);

    // Top of address space: no wrap
    r0 = rreq_cnt;
    plan(32'hffff_fff8, 32'hffff_fffc);
    launch(32'hffff_fff8, 32'hffff_fffc);
    wait_done("top_addr", 200);
    repeat (5) @(negedge clk);
    chk("top_addr_reads", rreq_cnt - r0, 32'd2);

    // Simultaneous start and end pulses: start wins, no launch
    @(negedge clk);
    uart_data = 32'h100; read_start_set = 1'b1; read_end_set = 1'b1;
    @(negedge clk);
    read_start_set = 1'b0; read_end_set = 1'b0;
    chk("both_no_launch", {31'b0, dump_running}, 32'd0);
    plan(32'h100, 32'h104);
    uart_data = 32'h104; read_end_set = 1'b1;
    @(negedge clk);
    read_end_set = 1'b0;
    wait_done("both_start_wins", 300);

    // Abort while the 3rd hex character is stalled
    lat_fixed = 1; ready_mode = 1;
    s = 32'h200; w = memval(s);
    exp_addr.push_back(s);
    for (int k = 0; k < 3; k++) exp_q.push_back(hexdig.getc(int'(w[31 - 4 * k -: 4])));
    base = acc_cnt;
    launch(s, s + 32'd8);
    c = 0;
    while (acc_cnt < base + 2 && c < 50) begin @(negedge clk); #3; c++; end
    chk("abort_hex_reach", {31'b0, c < 50}, 32'd1);
    ready_mode = 2;
    @(negedge clk);
    read_stop = 1'b1;
    @(negedge clk);
    read_stop = 1'b0;
    repeat (3) @(negedge clk);
    ready_mode = 1;
    wait_done("abort_hex", 60);
    repeat (12) @(negedge clk);
    chk("abort_hex_idle", {31'b0, dump_running}, 32'd0);

    // Abort in REQ and in WAIT: data discarded, no bytes
    abort_mem(32'h300, 0, "abort_req");
    abort_mem(32'h400, 1, "abort_wait");

    // Reset while a read is outstanding; the late rvalid must be ignored
    lat_fixed = 5; ready_mode = 1;
    exp_addr.push_back(32'h500);
    launch(32'h500, 32'h50c);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_running", {31'b0, dump_running}, 32'd0);
    chk("mid_rst_rreq", {31'b0, mem_rreq}, 32'd0);
    chk("mid_rst_raddr", mem_raddr, 32'd0);
    chk("mid_rst_txvalid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_txdata", {24'b0, tx_data}, 32'd0);
    chk("mid_rst_reads_left", exp_addr.size(), 32'd0);
    seen_valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_rvalid_ignored", {31'b0, seen_valid}, 32'd0);
    chk("late_rvalid_idle", {31'b0, dump_running}, 32'd0);

    // Random ranges, unaligned address bits, random stalls and latency
    for (int t = 0; t < 6; t++) begin
      lat_fixed = 0; ready_mode = 0; seed = $urandom;
      s = 32'($urandom_range(0, 32'h0fff)) + 32'd16;
      if ($urandom_range(0, 4) == 0) e = s - 32'd8;
      else e = (s & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(0, 3));
      plan(s, e);
      launch(s, e);
      wait_done("random", 3000);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
